stopwatch_lap: RTL and testbench
================================

# stopwatch_lap

Parametrised BCD stopwatch for the board-level timer designs: two active-low push-buttons (`KEY0`, `KEY1`) drive a run/stop/lap/clear state machine and a decimal counter advanced by an internal prescaler. Width, tick rate and debounce length are parameters. It adds on-chip debouncing, lap freeze and wrap signalling. Its BCD output feeds the seven-segment driver directly.

## Interface

- `CLK_FREQ`, 50_000_000, input clock frequency in Hz
- `TICK_HZ`, 100, count rate in Hz; `CLK_DIV = CLK_FREQ/TICK_HZ`, which must be ≥ 2 and an exact integer
- `DIGITS`, 6, number of BCD digits
- `DEBOUNCE_CYCLES`, 500_000, number of consecutive stable cycles needed to accept a key level (≥ 1)
- `clk`  in  1  single clock; all logic on the rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `KEY0`  in  1  start/stop button, raw, asynchronous, active-low
- `KEY1`  in  1  lap/clear button, raw, asynchronous, active-low
- `disp`  out  4*DIGITS  BCD display value; digit 0 is at bits [3:0]
- `running`  out  1  high in RUN and LAP
- `lap`  out  1  high in LAP (display frozen)
- `overflow`  out  1  one-cycle pulse when the count wraps from all-9s to all-0s

## Operation

- **Key path:** each key passes through
  - a 2-FF synchroniser, then
  - a debouncer: the debounced level takes the synchronised level once the two have differed for `DEBOUNCE_CYCLES` consecutive cycles; any agreement in between restarts the count.
  - A press event is a one-cycle pulse generated on the debounced 1→0 transition. Key release generates no event.
- **State machine:** states IDLE, RUN, STOP, LAP.
  - IDLE: KEY0 → RUN; KEY1 → no action.
  - RUN: KEY0 → STOP; KEY1 → LAP, and snapshot the current count into the lap register.
  - LAP: KEY0 → STOP, and the display returns to the live count; KEY1 → RUN.
  - STOP: KEY0 → RUN (resume); KEY1 → IDLE, clearing the count and prescaler.
- **Simultaneous press events:** KEY0 wins and the KEY1 event is discarded.
- **Prescaler:** counts 0..`CLK_DIV`-1 in RUN and LAP, holds its value in STOP, and is forced to 0 in IDLE.
- **Count:** `DIGITS` decimal digits with ripple carry.
  - Increments on the edge where the prescaler equals `CLK_DIV`-1 while running.
  - All-9s +1 gives all-0s and asserts `overflow` for that one cycle. Counting continues after the wrap.
- **Display:** `disp` shows the lap register in LAP and the live count in every other state.
- **Tick and stop on the same edge:** the increment is applied, then the count holds.
- **Lap snapshot on a tick edge:** the snapshot captures the pre-increment value.

## Timing

- **Reset values:** `disp`=0, `running`=0, `lap`=0, `overflow`=0.
  - State goes to IDLE; count, lap register and prescaler go to 0.
  - Debounced levels go to 1 (released) and debounce counters to 0.
  - Reset takes effect immediately on `rst_n` low, mid-operation included.
- **Key latency:** let edge E be the first edge at which `KEY0` is sampled low.
  - The press event is high in the cycle beginning at edge E+2+`DEBOUNCE_CYCLES`.
  - The state, `running` and `lap` change at the next edge.
- **Count latency:** entering RUN from IDLE resets the prescaler to 0, so the first increment lands exactly `CLK_DIV` cycles after the state change. Later increments follow every `CLK_DIV` cycles.
- **Resume from STOP:** the prescaler continues from its held value, so no partial period is lost or repeated.
- **Output registration:** all outputs are registered. `disp` updates on the same edge as the count or the state change.

## Test plan

All tests use `CLK_FREQ`=100, `TICK_HZ`=10 (`CLK_DIV`=10), `DIGITS`=2 and `DEBOUNCE_CYCLES`=4.

- **Start:** hold `KEY0` low for 10 cycles, then release.
  - `running` rises 7 cycles after the first low sample.
  - After a further 250 cycles, `disp`=8'h25.
  - Release generates no event.
- **Bounce:** toggle `KEY0` every 2 cycles for 40 cycles, then leave it high → no event and the state stays IDLE. Separately, a low glitch of 3 cycles is rejected.
- **Lap:** press `KEY1` at `disp`=8'h12.
  - `disp` holds 8'h12 while the internal count advances.
  - Pressing `KEY1` again at internal 8'h30 → `disp`=8'h30 live and `lap`=0.
- **Wrap:** run from 8'h98 for 20 cycles → `disp` goes 99 then 00, `overflow` is high for exactly one cycle, and `running` stays 1.
- **Stop, clear and priority:**
  - Press `KEY0` at 8'h47, then hold for 100 cycles → `disp` stays 8'h47.
  - Press `KEY0` and `KEY1` with identical timing → RUN only, and the count is not cleared.
  - Stop again, then press `KEY1` → `disp`=8'h00 and the state is IDLE.
- **Asynchronous reset:** drive `rst_n` low mid-cycle during RUN at 8'h63.
  - All outputs go to 0 before the next edge.
  - After release, the block needs a fresh `KEY0` press to restart.

Source files
------------

// File: rtl/stopwatch_lap.sv
// BCD stopwatch with debounced start/stop and lap/clear keys, lap freeze
// and a one-cycle wrap pulse when the count rolls over from all-9s.
module stopwatch_lap #(
    parameter int CLK_FREQ        = 50_000_000,
    parameter int TICK_HZ         = 100,
    parameter int DIGITS          = 6,
    parameter int DEBOUNCE_CYCLES = 500_000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  KEY0,
    input  logic                  KEY1,
    output logic [4*DIGITS-1:0]   disp,
    output logic                  running,
    output logic                  lap,
    output logic                  overflow
);

    localparam int CLK_DIV = CLK_FREQ / TICK_HZ;
    localparam int PW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int DW      = $clog2(DEBOUNCE_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, RUN, STOP, LAP} state_t;

    state_t               state;
    logic [1:0]           s1, s2, db, dbd, ev;
    logic [DW-1:0]        dcnt [2];
    logic [PW-1:0]        pre, pre_n;
    logic [4*DIGITS-1:0]  count, inc, adv, lapreg;
    logic                 cy, tick, e0, e1;

    // Bit 0 is KEY0, bit 1 is KEY1; keys idle high, so flops reset to 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1      <= '1;
            s2      <= '1;
            db      <= '1;
            dbd     <= '1;
            ev      <= '0;
            dcnt[0] <= '0;
            dcnt[1] <= '0;
        end else begin
            s1  <= {KEY1, KEY0};
            s2  <= s1;
            dbd <= db;
            ev  <= dbd & ~db;
            for (int unsigned i = 0; i < 2; i++) begin
                if (s2[i] != db[i]) begin
                    if (dcnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
                        db[i]   <= s2[i];
                        dcnt[i] <= '0;
                    end else begin
                        dcnt[i] <= dcnt[i] + DW'(1);
                    end
                end else begin
                    dcnt[i] <= '0;
                end
            end
        end
    end

    // Ripple-carry BCD increment; cy is left high only for an all-9s count.
    always_comb begin
        inc = count;
        cy  = 1'b1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (cy) begin
                if (count[4*i +: 4] == 4'd9) begin
                    inc[4*i +: 4] = 4'd0;
                end else begin
                    inc[4*i +: 4] = count[4*i +: 4] + 4'd1;
                    cy            = 1'b0;
                end
            end
        end
    end

    assign tick  = (pre == PW'(CLK_DIV - 1));
    assign pre_n = tick ? '0 : pre + PW'(1);
    assign adv   = tick ? inc : count;
    assign e0    = ev[0];
    assign e1    = ev[1] & ~ev[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            pre      <= '0;
            count    <= '0;
            lapreg   <= '0;
            disp     <= '0;
            running  <= 1'b0;
            lap      <= 1'b0;
            overflow <= 1'b0;
        end else begin
            overflow <= 1'b0;
            case (state)
                IDLE: begin
                    pre  <= '0;
                    disp <= count;
                    if (e0) begin
                        state   <= RUN;
                        running <= 1'b1;
                    end
                end
                RUN: begin
                    pre      <= pre_n;
                    count    <= adv;
                    overflow <= tick & cy;
                    if (e0) begin
                        state   <= STOP;
                        running <= 1'b0;
                        disp    <= adv;
                    end else if (e1) begin
                        // Snapshot takes the pre-increment value on a tick edge.
                        state  <= LAP;
                        lap    <= 1'b1;
                        lapreg <= count;
                        disp   <= count;
                    end else begin
                        disp <= adv;
                    end
                end
                LAP: begin
                    pre      <= pre_n;
                    count    <= adv;
                    overflow <= tick & cy;
                    if (e0) begin
                        state   <= STOP;
                        running <= 1'b0;
                        lap     <= 1'b0;
                        disp    <= adv;
                    end else if (e1) begin
                        state <= RUN;
                        lap   <= 1'b0;
                        disp  <= adv;
                    end else begin
                        disp <= lapreg;
                    end
                end
                STOP: begin
                    if (e0) begin
                        state   <= RUN;
                        running <= 1'b1;
                        disp    <= count;
                    end else if (e1) begin
                        state <= IDLE;
                        count <= '0;
                        pre   <= '0;
                        disp  <= '0;
                    end else begin
                        disp <= count;
                    end
                end
                default: begin
                    state   <= IDLE;
                    running <= 1'b0;
                    lap     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stopwatch_lap.sv
// Directed bench for stopwatch_lap with CLK_DIV=10, two digits, 4-cycle debounce.
module tb_stopwatch_lap;

    logic       clk;
    logic       rst_n;
    logic       KEY0;
    logic       KEY1;
    logic [7:0] disp;
    logic       running;
    logic       lap;
    logic       overflow;

    int checks   = 0;
    int failures = 0;

    stopwatch_lap #(
        .CLK_FREQ       (100),
        .TICK_HZ        (10),
        .DIGITS         (2),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .KEY0    (KEY0),
        .KEY1    (KEY1),
        .disp    (disp),
        .running (running),
        .lap     (lap),
        .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        cyc(1);
    endtask

    // Keys low for 8 edges; the state change lands on the 8th edge, then release.
    task automatic press(input logic k0, input logic k1);
        KEY0 = ~k0;
        KEY1 = ~k1;
        cyc(8);
        KEY0 = 1'b1;
        KEY1 = 1'b1;
    endtask

    task automatic start_run();
        do_reset();
        press(1'b1, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        KEY0  = 1'b1;
        KEY1  = 1'b1;
        cyc(2);
        chk("rst_disp", disp, 0);
        chk("rst_running", running, 0);
        chk("rst_lap", lap, 0);
        chk("rst_overflow", overflow, 0);
        rst_n = 1'b1;
        cyc(1);

        // Start: first low sample at edge E, running at E+7
        KEY0 = 1'b0;
        cyc(7);
        chk("start_not_yet", running, 0);
        cyc(1);
        chk("start_running", running, 1);
        cyc(2);
        KEY0 = 1'b1;
        cyc(247);
        chk("start_disp24", disp, 8'h24);
        cyc(1);
        chk("start_disp25", disp, 8'h25);
        chk("release_no_event", running, 1);

        // Bounce and glitch rejection, then a minimum-length accepted press
        do_reset();
        for (int i = 0; i < 20; i++) begin
            KEY0 = (i % 2 == 0) ? 1'b0 : 1'b1;
            cyc(2);
        end
        KEY0 = 1'b1;
        cyc(20);
        chk("bounce_idle", running, 0);
        KEY0 = 1'b0;
        cyc(3);
        KEY0 = 1'b1;
        cyc(20);
        chk("glitch3_idle", running, 0);
        KEY0 = 1'b0;
        cyc(4);
        KEY0 = 1'b1;
        cyc(20);
        chk("press4_accepted", running, 1);

        // Lap snapshot on a tick edge (T+130) holds 12, live count continues
        start_run();
        cyc(122);
        press(1'b0, 1'b1);
        chk("lap_flag", lap, 1);
        chk("lap_snap12", disp, 8'h12);
        cyc(70);
        chk("lap_frozen", disp, 8'h12);
        chk("lap_running", running, 1);
        cyc(97);
        press(1'b0, 1'b1);
        chk("unlap_disp30", disp, 8'h30);
        chk("unlap_flag", lap, 0);

        // Wrap 99 -> 00 at T+1000
        start_run();
        cyc(999);
        chk("wrap_disp99", disp, 8'h99);
        chk("wrap_ovf_pre", overflow, 0);
        cyc(1);
        chk("wrap_disp00", disp, 8'h00);
        chk("wrap_ovf", overflow, 1);
        cyc(1);
        chk("wrap_ovf_post", overflow, 0);
        chk("wrap_running", running, 1);

        // Stop on a tick edge (46 -> 47), hold, priority resume, stop, clear
        start_run();
        cyc(462);
        press(1'b1, 1'b0);
        chk("stop_disp47", disp, 8'h47);
        chk("stop_running", running, 0);
        cyc(100);
        chk("stop_hold47", disp, 8'h47);
        press(1'b1, 1'b1);
        chk("prio_running", running, 1);
        chk("prio_lap", lap, 0);
        chk("prio_not_cleared", disp, 8'h47);
        cyc(9);
        chk("resume_disp47", disp, 8'h47);
        cyc(1);
        chk("resume_disp48", disp, 8'h48);
        cyc(2);
        press(1'b1, 1'b0);
        chk("stop2_disp49", disp, 8'h49);
        chk("stop2_running", running, 0);
        cyc(12);
        press(1'b0, 1'b1);
        chk("clear_disp", disp, 8'h00);
        chk("clear_running", running, 0);
        cyc(30);
        chk("idle_no_count", disp, 8'h00);

        // Asynchronous reset mid-cycle at 63
        start_run();
        cyc(635);
        chk("areset_pre63", disp, 8'h63);
        #3;
        rst_n = 1'b0;
        #1;
        chk("areset_disp", disp, 0);
        chk("areset_running", running, 0);
        chk("areset_lap", lap, 0);
        chk("areset_ovf", overflow, 0);
        cyc(1);
        rst_n = 1'b1;
        cyc(50);
        chk("post_reset_idle", running, 0);
        chk("post_reset_disp", disp, 0);
        press(1'b1, 1'b0);
        chk("post_reset_restart", running, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
